l4_acc_ctrl: RTL and testbench

//  Sequences read-modify-write accumulation of layer-4 partial sums into the 64x36b l4_ram.

---
 rtl/l4_acc_ctrl.sv | 157 +++++++++++++++
 tb/tb_l4_acc_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l4_acc_ctrl.sv
// l4_acc_ctrl: read-modify-write accumulation controller for the layer-4
// partial-sum RAM. Each accepted 16-lane beat is summed with the RAM window
// it targets and written back one cycle later. The first input channel
// overwrites the window, so the RAM never needs a separate clear pass.
module l4_acc_ctrl #(
  parameter int LANES  = 16,
  parameter int DW     = 36,
  parameter int AW     = 6,
  parameter int GROUPS = 4,
  parameter int CH_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_W-1:0]       num_ch,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic                  in_last,
  output logic                  wr,
  output logic [AW-1:0]         addr_wr,
  output logic [LANES*DW-1:0]   din,
  input  logic [LANES*DW-1:0]   dout_wr,
  output logic                  done,
  input  logic                  out_ack,
  output logic                  err
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [GW-1:0]       r_grp;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_num_ch;
  logic                r_err;

  logic                r_vld_p0;
  logic                r_first_p0;
  logic [AW-1:0]       r_addr_p0;
  logic [LANES*DW-1:0] r_data_p0;

  logic                w_start_ok;
  logic                w_accept;
  logic                w_final;
  logic [LANES*DW-1:0] w_din;

  // Two's-complement add that wraps modulo 2**DW; no saturation on purpose.
  function automatic logic signed [DW-1:0] f_add_wrap(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return a + b;
  endfunction

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_accept   = in_valid && (r_state == S_ACCUM);
  assign w_final    = (r_ch == r_num_ch - CH_W'(1)) && (r_grp == GW'(GROUPS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: a zero channel count never leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (num_ch != '0)) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_accept && w_final)     w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  if (out_ack)                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Group/channel counters; group wraps into the channel count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grp    <= '0;
      r_ch     <= '0;
      r_num_ch <= '0;
    end else if (w_start_ok) begin
      r_grp    <= '0;
      r_ch     <= '0;
      r_num_ch <= num_ch;
    end else if (w_accept) begin
      if (r_grp == GW'(GROUPS - 1)) begin
        r_grp <= '0;
        r_ch  <= r_ch + CH_W'(1);
      end else begin
        r_grp <= r_grp + GW'(1);
      end
    end
  end

  // Sticky error: bad channel count at start or in_last disagreeing with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_err <= 1'b0;
    else if (w_start_ok)                       r_err <= (num_ch == '0);
    else if (w_accept && (in_last != w_final)) r_err <= 1'b1;
  end

  // ---- stage p0: accepted beat registered with its window and first-channel flag ----
  // Control half of the stage; addr holds when no beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0   <= 1'b0;
      r_first_p0 <= 1'b0;
      r_addr_p0  <= '0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_first_p0 <= (r_ch == '0);
        r_addr_p0  <= AW'(int'(r_grp) * LANES);
      end
    end
  end

  // Data half of the stage carries no reset; it is qualified by r_vld_p0.
  always_ff @(posedge clk) begin
    if (w_accept) r_data_p0 <= in_data;
  end

  // ---- write stage: combinational sum against the RAM window read ----
  // First channel overwrites; later channels add onto what the RAM holds.
  always_comb begin
    w_din = '0;
    if (r_vld_p0) begin
      for (int j = 0; j < LANES; j++) begin
        if (r_first_p0)
          w_din[j*DW +: DW] = r_data_p0[j*DW +: DW];
        else
          w_din[j*DW +: DW] = f_add_wrap(dout_wr[j*DW +: DW], r_data_p0[j*DW +: DW]);
      end
    end
  end

  assign wr       = r_vld_p0;
  assign addr_wr  = r_addr_p0;
  assign din      = w_din;
  assign in_ready = (r_state == S_ACCUM);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;

endmodule

// File: tb/tb_l4_acc_ctrl.sv
// Directed bench for l4_acc_ctrl with a behavioural 64x36 RAM beside the DUT.
module tb_l4_acc_ctrl;

  localparam int LANES  = 16;
  localparam int DW     = 36;
  localparam int AW     = 6;
  localparam int GROUPS = 4;
  localparam int CH_W   = 8;
  localparam int DEPTH  = 64;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [CH_W-1:0]      num_ch;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*DW-1:0]  in_data;
  logic                 in_last;
  logic                 wr;
  logic [AW-1:0]        addr_wr;
  logic [LANES*DW-1:0]  din;
  logic [LANES*DW-1:0]  dout_wr;
  logic                 done;
  logic                 out_ack;
  logic                 err;

  logic [DW-1:0]        ram [DEPTH];
  logic                 pre_en;
  logic [DW-1:0]        pre_base;
  int                   n_wr;

  int n_chk;
  int n_fail;

  l4_acc_ctrl #(
    .LANES(LANES), .DW(DW), .AW(AW), .GROUPS(GROUPS), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr(wr), .addr_wr(addr_wr), .din(din), .dout_wr(dout_wr),
    .done(done), .out_ack(out_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preload port for garbage, otherwise the DUT's write window.
  initial n_wr = 0;
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pre_base + DW'(i);
    end else if (wr) begin
      for (int j = 0; j < LANES; j++) ram[int'(addr_wr) + j] <= din[j*DW +: DW];
      n_wr <= n_wr + 1;
    end
  end

  always_comb begin
    dout_wr = '0;
    for (int j = 0; j < LANES; j++) dout_wr[j*DW +: DW] = ram[int'(addr_wr) + j];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] ramp(input int base);
    logic [LANES*DW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*DW +: DW] = DW'(base + j);
    return r;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic preload(input logic [DW-1:0] base);
    pre_en = 1'b1; pre_base = base;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_ch = CH_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*DW-1:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("beat_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic ack_pass();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int bad;
    logic [DW-1:0] v;
    logic [LANES*DW-1:0] d;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; num_ch = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ack = 1'b0; pre_en = 1'b0; pre_base = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_wr", 64'(wr), 64'd0);
    check_eq("rst_addr", 64'(addr_wr), 64'd0);
    check_eq("rst_din", 64'(din[63:0]), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: single channel, lane value k+16g -> RAM[i]=i, exact done timing.
    preload(36'h5A5A0000);
    w0 = n_wr;
    do_start(1);
    check_eq("t1_busy", 64'(busy), 64'd1);
    check_eq("t1_in_ready", 64'(in_ready), 64'd1);
    for (int g = 0; g < GROUPS; g++) send_beat(ramp(16*g), g == GROUPS-1);
    @(negedge clk);
    check_eq("t1_flush_wr", 64'(wr), 64'd1);
    check_eq("t1_flush_addr", 64'(addr_wr), 64'd48);
    check_eq("t1_flush_din_lane15", 64'(din[15*DW +: DW]), 64'd63);
    check_eq("t1_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("t1_done_at_t2", 64'(done), 64'd1);
    check_eq("t1_wr_idle", 64'(wr), 64'd0);
    check_eq("t1_addr_hold", 64'(addr_wr), 64'd48);
    check_eq("t1_in_ready_done", 64'(in_ready), 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== DW'(i)) bad++;
    check_eq("t1_ram_bad_entries", 64'(bad), 64'd0);
    check_eq("t1_ram_37", 64'(ram[37]), 64'd37);
    check_eq("t1_writes", 64'(n_wr - w0), 64'd4);
    repeat (3) @(negedge clk);
    check_eq("t1_done_hold", 64'(done), 64'd1);
    ack_pass();
    check_eq("t1_busy_after_ack", 64'(busy), 64'd0);
    check_eq("t1_done_after_ack", 64'(done), 64'd0);
    check_eq("t1_err", 64'(err), 64'd0);

    // Test 2: three channels +5, -2, +1 over garbage -> 4 everywhere; stray start ignored.
    preload(36'hF0F0F);
    w0 = n_wr;
    do_start(3);
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       v = 36'd5;
        1:       v = -36'sd2;
        default: v = 36'd1;
      endcase
      for (int g = 0; g < GROUPS; g++) begin
        if (c == 1 && g == 0) begin start = 1'b1; num_ch = '0; end
        send_beat(fill(v), c == 2 && g == GROUPS-1);
        start = 1'b0;
      end
    end
    wait_done("t2_done");
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 36'd4) bad++;
    check_eq("t2_ram_bad_entries", 64'(bad), 64'd0);
    check_eq("t2_ram_0", 64'(ram[0]), 64'd4);
    check_eq("t2_ram_63", 64'(ram[63]), 64'd4);
    check_eq("t2_writes", 64'(n_wr - w0), 64'd12);
    check_eq("t2_err", 64'(err), 64'd0);
    ack_pass();

    // Test 3: gaps in in_valid; ch0 writes i+100, ch1 adds -1 -> i+99.
    w0 = n_wr;
    do_start(2);
    for (int b = 0; b < 2*GROUPS; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (b < GROUPS) d = ramp(16*b + 100);
      else            d = fill(-36'sd1);
      send_beat(d, b == 2*GROUPS-1);
    end
    wait_done("t3_done");
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== DW'(i + 99)) bad++;
    check_eq("t3_ram_bad_entries", 64'(bad), 64'd0);
    check_eq("t3_ram_20", 64'(ram[20]), 64'd119);
    check_eq("t3_writes", 64'(n_wr - w0), 64'd8);
    check_eq("t3_err", 64'(err), 64'd0);
    ack_pass();

    // Test 4: 2**35-1 plus 1 wraps to -2**35 without err.
    do_start(2);
    for (int g = 0; g < GROUPS; g++) begin
      d = '0;
      if (g == 0) d[5*DW +: DW] = 36'h7_FFFF_FFFF;
      send_beat(d, 1'b0);
    end
    for (int g = 0; g < GROUPS; g++) send_beat(fill(36'd1), g == GROUPS-1);
    wait_done("t4_done");
    check_eq("t4_ram_5_wrap", 64'(ram[5]), 64'h8_0000_0000);
    check_eq("t4_ram_4", 64'(ram[4]), 64'd1);
    check_eq("t4_ram_63", 64'(ram[63]), 64'd1);
    check_eq("t4_err", 64'(err), 64'd0);
    ack_pass();

    // Test 5: in_last early on beat 2 -> err, pass completes; next start clears err.
    do_start(1);
    for (int g = 0; g < GROUPS; g++) send_beat(ramp(16*g + 1000), g == 1);
    wait_done("t5_done");
    check_eq("t5_err_set", 64'(err), 64'd1);
    check_eq("t5_ram_63", 64'(ram[63]), 64'd1063);
    ack_pass();
    check_eq("t5_err_sticky_idle", 64'(err), 64'd1);
    do_start(1);
    check_eq("t5_err_cleared", 64'(err), 64'd0);
    for (int g = 0; g < GROUPS; g++) send_beat(fill(36'd0), g == GROUPS-1);
    wait_done("t5_done2");
    check_eq("t5_err_clean_pass", 64'(err), 64'd0);
    ack_pass();
    // Zero channel count flags err and stays idle.
    do_start(0);
    check_eq("t5_zero_ch_err", 64'(err), 64'd1);
    check_eq("t5_zero_ch_busy", 64'(busy), 64'd0);

    // Test 6: reset after 5 committed writes with a 6th in flight.
    do_start(2);
    for (int b = 0; b < 6; b++) send_beat(fill(b < GROUPS ? 36'd10 : 36'd7), 1'b0);
    check_eq("t6_wr_before_rst", 64'(wr), 64'd1);
    w0 = n_wr;
    rst = 1'b1;
    #1;
    check_eq("t6_wr_in_rst", 64'(wr), 64'd0);
    check_eq("t6_busy_in_rst", 64'(busy), 64'd0);
    check_eq("t6_in_ready_in_rst", 64'(in_ready), 64'd0);
    check_eq("t6_err_in_rst", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_no_more_writes", 64'(n_wr - w0), 64'd0);
    check_eq("t6_idle_busy", 64'(busy), 64'd0);
    check_eq("t6_ram_0", 64'(ram[0]), 64'd17);
    check_eq("t6_ram_15", 64'(ram[15]), 64'd17);
    check_eq("t6_ram_16", 64'(ram[16]), 64'd10);
    check_eq("t6_ram_63", 64'(ram[63]), 64'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
